// File: rtl/fir_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fir_pkg : shared types and defaults for the FIR control sequencer |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package fir_pkg;

    localparam int FIR_ADDR_WIDTH = 13;
    localparam int FIR_RAM_LAT    = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } fir_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/fir_ctrl_lat_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fir_ctrl_lat_pipe : DEPTH-deep valid shift line aligning MAC      |
// | enables with RAM read data. Revision: 1.0                         |
// +------------------------------------------------------------------+
module fir_ctrl_lat_pipe #(
    parameter int DEPTH = 1
) (
    input  logic a_clk,
    input  logic a_rst,
    input  logic flush_i,
    input  logic valid_i,
    output logic valid_o
);

    logic [DEPTH-1:0] line_q;

    if (DEPTH == 1) begin : g_single
        always_ff @(posedge a_clk or posedge a_rst) begin
            if (a_rst) begin
                line_q <= '0;
            end else if (flush_i) begin
                line_q <= '0;
            end else begin
                line_q <= valid_i;
            end
        end
    end else begin : g_multi
        always_ff @(posedge a_clk or posedge a_rst) begin
            if (a_rst) begin
                line_q <= '0;
            end else if (flush_i) begin
                line_q <= '0;
            end else begin
                line_q <= {line_q[DEPTH-2:0], valid_i};
            end
        end
    end

    assign valid_o = line_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fir_ctrl_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fir_ctrl_fsm : walks every output sample, issues tap addresses,   |
// | drives MAC enables and output writes. Optional FIR_CTRL_ABORT_EN. |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module fir_ctrl_fsm
    import fir_pkg::*;
#(
    parameter int ADDR_WIDTH = FIR_ADDR_WIDTH,
    parameter int RAM_LAT    = FIR_RAM_LAT
) (
    input  logic                  a_clk,
    input  logic                  a_rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_samples,
    input  logic [ADDR_WIDTH:0]   num_taps,
    output logic                  busy,
    output logic                  done,
    output logic                  fsm_mux_wej,
    output logic                  fsm_mux_wyj,
    output logic [ADDR_WIDTH-1:0] adres_probki_fir,
    output logic [ADDR_WIDTH-1:0] adres_wsp,
    output logic [ADDR_WIDTH-1:0] adres_probki_wyn_fir,
    output logic                  fsm_wyj_wr,
    output logic                  mac_clr,
    output logic                  mac_en
`ifdef FIR_CTRL_ABORT_EN
    ,
    input  logic                  abort,
    output logic                  aborted
`endif
);

    localparam logic [ADDR_WIDTH:0] c_ONE        = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [2:0]          c_DRAIN_LAST = 3'(RAM_LAT - 1);

    fir_ctrl_state_t       state_q, state_d;
    logic [ADDR_WIDTH-1:0] n_q, n_d, k_q, k_d;
    logic [2:0]            drain_q, drain_d;
    logic [ADDR_WIDTH:0]   samples_q, samples_d, taps_q, taps_d;
    logic                  abort_req;
    logic                  last_tap, last_sample, no_taps;

`ifdef FIR_CTRL_ABORT_EN
    logic aborted_q;

    assign abort_req = abort && (state_q != IDLE);

    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort_req;
        end
    end

    assign aborted = aborted_q;
`else
    assign abort_req = 1'b0;
`endif

    // K(n) = min(n+1, T): tap k is the last one when k == n or k+1 == T.
    assign last_tap    = (k_q == n_q) || (({1'b0, k_q} + c_ONE) == taps_q);
    assign last_sample = (({1'b0, n_q} + c_ONE) == samples_q);
    assign no_taps     = (taps_q == '0);

    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            k_q       <= '0;
            drain_q   <= '0;
            samples_q <= '0;
            taps_q    <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            k_q       <= k_d;
            drain_q   <= drain_d;
            samples_q <= samples_d;
            taps_q    <= taps_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        n_d                  = n_q;
        k_d                  = k_q;
        drain_d              = drain_q;
        samples_d            = samples_q;
        taps_d               = taps_q;
        busy                 = (state_q != IDLE);
        fsm_mux_wej          = (state_q != IDLE);
        fsm_mux_wyj          = (state_q != IDLE);
        done                 = 1'b0;
        mac_clr              = 1'b0;
        fsm_wyj_wr           = 1'b0;
        adres_probki_fir     = '0;
        adres_wsp            = '0;
        adres_probki_wyn_fir = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    samples_d = num_samples;
                    taps_d    = num_taps;
                    state_d   = INIT;
                end
            end
            INIT: begin
                mac_clr = 1'b1;
                n_d     = '0;
                k_d     = '0;
                drain_d = '0;
                if (samples_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = no_taps ? DRAIN : MAC;
                end
            end
            MAC: begin
                if (last_tap) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == c_DRAIN_LAST) begin
                    state_d = WRITE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            WRITE: begin
                fsm_wyj_wr = 1'b1;
                mac_clr    = 1'b1;
                if (last_sample) begin
                    state_d = DONE;
                end else begin
                    n_d     = n_q + 1'b1;
                    k_d     = '0;
                    drain_d = '0;
                    state_d = no_taps ? DRAIN : MAC;
                end
            end
            DONE: begin
                done    = 1'b1;
                n_d     = '0;
                k_d     = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if ((state_q == MAC) || (state_q == DRAIN) || (state_q == WRITE)) begin
            adres_probki_fir     = n_q - k_q;
            adres_wsp            = k_q;
            adres_probki_wyn_fir = n_q;
        end

        if (abort_req) begin
            state_d = IDLE;
            n_d     = '0;
            k_d     = '0;
            drain_d = '0;
        end
    end

    fir_ctrl_lat_pipe #(
        .DEPTH (RAM_LAT)
    ) u_lat_pipe (
        .a_clk   (a_clk),
        .a_rst   (a_rst),
        .flush_i (abort_req),
        .valid_i (state_q == MAC),
        .valid_o (mac_en)
    );

endmodule
`default_nettype wire

// File: tb/tb_fir_ctrl_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fir_ctrl_fsm : cycle-trace reference check of two sequencers   |
// | (RAM_LAT 1 and 3) driven in lockstep. Revision: 1.0               |
// +------------------------------------------------------------------+
module tb_fir_ctrl_fsm;

    localparam int AW    = 13;
    localparam int OBS_W = 7 + 3 * AW;
    localparam logic [1:0] K_OTHER = 2'd0;
    localparam logic [1:0] K_MAC   = 2'd1;
    localparam logic [1:0] K_DRAIN = 2'd2;
    localparam logic [1:0] K_WRITE = 2'd3;

    typedef struct packed {
        logic          busy, done, mux, wr, clr;
        logic [1:0]    kind;
        logic [AW-1:0] ain, awsp, aout;
    } rec_t;

    logic          a_clk = 1'b0;
    logic          a_rst, start;
    logic [AW:0]   num_samples, num_taps;
    logic          busy_a, done_a, wej_a, wyj_a, wr_a, clr_a, en_a;
    logic          busy_b, done_b, wej_b, wyj_b, wr_b, clr_b, en_b;
    logic [AW-1:0] ain_a, awsp_a, aout_a, ain_b, awsp_b, aout_b;
    int            n_cmp = 0;
    int            n_err = 0;
`ifdef FIR_CTRL_ABORT_EN
    logic          abort, aborted_a, aborted_b;
`endif

    always #5 a_clk = ~a_clk;

    fir_ctrl_fsm #(.ADDR_WIDTH(AW), .RAM_LAT(1)) u_dut_l1 (
        .a_clk(a_clk), .a_rst(a_rst), .start(start),
        .num_samples(num_samples), .num_taps(num_taps),
        .busy(busy_a), .done(done_a), .fsm_mux_wej(wej_a), .fsm_mux_wyj(wyj_a),
        .adres_probki_fir(ain_a), .adres_wsp(awsp_a), .adres_probki_wyn_fir(aout_a),
        .fsm_wyj_wr(wr_a), .mac_clr(clr_a), .mac_en(en_a)
`ifdef FIR_CTRL_ABORT_EN
        , .abort(abort), .aborted(aborted_a)
`endif
    );

    fir_ctrl_fsm #(.ADDR_WIDTH(AW), .RAM_LAT(3)) u_dut_l3 (
        .a_clk(a_clk), .a_rst(a_rst), .start(start),
        .num_samples(num_samples), .num_taps(num_taps),
        .busy(busy_b), .done(done_b), .fsm_mux_wej(wej_b), .fsm_mux_wyj(wyj_b),
        .adres_probki_fir(ain_b), .adres_wsp(awsp_b), .adres_probki_wyn_fir(aout_b),
        .fsm_wyj_wr(wr_b), .mac_clr(clr_b), .mac_en(en_b)
`ifdef FIR_CTRL_ABORT_EN
        , .abort(abort), .aborted(aborted_b)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [OBS_W-1:0] obs_all(input int d);
        if (d == 0) return {busy_a, done_a, wej_a, wyj_a, wr_a, clr_a, en_a, ain_a, awsp_a, aout_a};
        return {busy_b, done_b, wej_b, wyj_b, wr_b, clr_b, en_b, ain_b, awsp_b, aout_b};
    endfunction

    function automatic int taps_of(input int n, input int tt);
        return (n + 1 < tt) ? n + 1 : tt;
    endfunction

    function automatic int run_len(input int lat, input int nn, input int tt);
        int s = 2;
        for (int n = 0; n < nn; n++) s += taps_of(n, tt) + lat + 1;
        return s;
    endfunction

    // Expected behaviour of cycle j after the start edge (j = 0 is INIT).
    function automatic rec_t exp_at(input int lat, input int nn, input int tt, input int j);
        rec_t r;
        int   c, kk, off, total;
        r     = '0;
        total = run_len(lat, nn, tt);
        if (j < 0 || j >= total) return r;
        r.busy = 1'b1;
        r.mux  = 1'b1;
        if (j == 0) begin
            r.clr = 1'b1;
            return r;
        end
        if (j == total - 1) begin
            r.done = 1'b1;
            return r;
        end
        c = 1;
        for (int n = 0; n < nn; n++) begin
            kk = taps_of(n, tt);
            if (j < c + kk + lat + 1) begin
                off = j - c;
                if (off < kk) begin
                    r.kind = K_MAC;
                    r.ain  = AW'(n - off);
                    r.awsp = AW'(off);
                end else if (off < kk + lat) begin
                    r.kind = K_DRAIN;
                end else begin
                    r.kind = K_WRITE;
                    r.wr   = 1'b1;
                    r.clr  = 1'b1;
                    r.aout = AW'(n);
                end
                return r;
            end
            c += kk + lat + 1;
        end
        return r;
    endfunction

    task automatic check_cycle(input int nn, input int tt, input int j, input logic killed);
        rec_t             e;
        logic             e_en;
        logic [OBS_W-1:0] o;
        int               lat;
        string            p;
        for (int d = 0; d < 2; d++) begin
            lat  = (d == 0) ? 1 : 3;
            e    = killed ? '0 : exp_at(lat, nn, tt, j);
            e_en = killed ? 1'b0 : (exp_at(lat, nn, tt, j - lat).kind == K_MAC);
            o    = obs_all(d);
            p    = $sformatf("L%0d N%0d T%0d j%0d", lat, nn, tt, j);
            check_eq({p, " ctrl"}, 64'(o[OBS_W-1 -: 7]),
                     64'({e.busy, e.done, e.mux, e.mux, e.wr, e.clr, e_en}));
            if (e.kind == K_MAC)
                check_eq({p, " rd_addr"}, 64'(o[3*AW-1:AW]), 64'({e.ain, e.awsp}));
            else if (e.kind == K_WRITE)
                check_eq({p, " wr_addr"}, 64'(o[AW-1:0]), 64'(e.aout));
            else if (e.kind == K_OTHER)
                check_eq({p, " addr_zero"}, 64'(o[3*AW-1:0]), 64'd0);
        end
    endtask

    task automatic run_case(input int nn, input int tt, input int mid_j, input int rst_j,
                            input int abort_j, output int first_done);
        int len, kill_j;
        len        = run_len(3, nn, tt) + 2;
        kill_j     = 1 << 30;
        first_done = -1;
        @(negedge a_clk);
        start       = 1'b1;
        num_samples = (AW+1)'(nn);
        num_taps    = (AW+1)'(tt);
        for (int j = 0; j < len; j++) begin
            @(negedge a_clk);
            a_rst       = 1'b0;
            start       = 1'b0;
            num_samples = (AW+1)'($urandom);
            num_taps    = (AW+1)'($urandom);
`ifdef FIR_CTRL_ABORT_EN
            abort = 1'b0;
            check_eq($sformatf("aborted j%0d", j), 64'({aborted_a, aborted_b}),
                     (abort_j >= 0 && j == abort_j + 1) ? 64'd3 : 64'd0);
`endif
            check_cycle(nn, tt, j, j > kill_j);
            if (done_a && first_done < 0) first_done = j;
            if (j == mid_j) begin
                start       = 1'b1;
                num_samples = (AW+1)'(9);
            end
            if (j == abort_j) begin
`ifdef FIR_CTRL_ABORT_EN
                abort = 1'b1;
`endif
                kill_j = j;
            end
            if (j == rst_j) begin
                #2 a_rst = 1'b1;
                #1;
                check_eq("rst_async L1", 64'(obs_all(0)), 64'd0);
                check_eq("rst_async L3", 64'(obs_all(1)), 64'd0);
                kill_j = j;
            end
        end
    endtask

    initial begin
        int fd, rj, nn, tt;
        a_rst       = 1'b1;
        start       = 1'b0;
        num_samples = '0;
        num_taps    = '0;
`ifdef FIR_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge a_clk);
        check_eq("reset L1", 64'(obs_all(0)), 64'd0);
        check_eq("reset L3", 64'(obs_all(1)), 64'd0);
        a_rst = 1'b0;

        run_case(4, 3, -1, -1, -1, fd);
        check_eq("done_cycle N4T3", 64'(fd + 1), 64'd19);
        run_case(0, 5, -1, -1, -1, fd);
        check_eq("done_cycle N0", 64'(fd + 1), 64'd2);
        run_case(3, 0, -1, -1, -1, fd);
        run_case(5, 2, 2, -1, -1, fd);

        rj = 0;
        while (!(exp_at(1, 5, 3, rj).kind == K_MAC &&
                 exp_at(1, 5, 3, rj).ain + exp_at(1, 5, 3, rj).awsp == AW'(2))) rj++;
        run_case(5, 3, -1, rj, -1, fd);
        check_eq("no_done_after_rst", 64'(fd), 64'hFFFF_FFFF_FFFF_FFFF);
        run_case(4, 3, -1, -1, -1, fd);

`ifdef FIR_CTRL_ABORT_EN
        @(negedge a_clk);
        abort = 1'b1;
        @(negedge a_clk);
        abort = 1'b0;
        check_eq("abort_idle_ignored", 64'({aborted_a, aborted_b, busy_a, busy_b}), 64'd0);
        rj = 4;
        while (exp_at(1, 4, 3, rj).kind != K_DRAIN) rj++;
        run_case(4, 3, -1, -1, rj, fd);
        check_eq("no_done_after_abort", 64'(fd), 64'hFFFF_FFFF_FFFF_FFFF);
`endif

        for (int i = 0; i < 12; i++) begin
            nn = int'($urandom_range(0, 6));
            tt = int'($urandom_range(0, 8));
            run_case(nn, tt, -1, -1, -1, fd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_ctrl_fsm.md
Name: fir_ctrl_fsm

Overview:
- Sequencer for the FIR datapath behind the AXI sample RAMs.
- On start, takes ownership of the input and output RAM address muxes and walks every output sample n.
- For each sample, issues input-RAM and coefficient-RAM addresses tap by tap, drives the MAC enables and writes each result into the output RAM.
- Releases both muxes to AXI when the run finishes.

Parameters:
- ADDR_WIDTH, 13, address width of input, output and coefficient RAMs.
- RAM_LAT, 1, read latency of the sample/coefficient RAMs in cycles (1..4).

Ports:
- a_clk  in  1  clock.
- a_rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle run request; ignored while busy.
- num_samples  in  ADDR_WIDTH+1  sample count N (0..2^ADDR_WIDTH); latched at start.
- num_taps  in  ADDR_WIDTH+1  tap count T; latched at start.
- busy  out  1  high from the cycle after an accepted start until DONE exits.
- done  out  1  one-cycle pulse in DONE.
- fsm_mux_wej  out  1  1 = FIR owns the input-RAM address.
- fsm_mux_wyj  out  1  1 = FIR owns the output-RAM address.
- adres_probki_fir  out  ADDR_WIDTH  input-RAM read address (n-k).
- adres_wsp  out  ADDR_WIDTH  coefficient-RAM read address (k).
- adres_probki_wyn_fir  out  ADDR_WIDTH  output-RAM write address (n).
- fsm_wyj_wr  out  1  output-RAM write strobe.
- mac_clr  out  1  clear datapath accumulator at the next edge.
- mac_en  out  1  accumulate h[k]*x[n-k] at the next edge; aligned to RAM data.

Behaviour:
- Reset: all outputs 0, state IDLE, counters n=k=0.
- States: IDLE, INIT, MAC, DRAIN, WRITE, DONE.
- IDLE:
  - muxes 0.
  - start=1 latches N and T, goes to INIT.
- INIT (1 cycle):
  - muxes 1, mac_clr=1, n=0.
  - N=0 goes to DONE; otherwise goes to MAC with k=0.
- MAC:
  - K(n)=min(n+1,T) cycles, k=0..K-1.
  - adres_probki_fir=n-k, adres_wsp=k. n-k never underflows because k<=n, so x[<0] is treated as zero by omission.
  - A valid bit enters a RAM_LAT-deep shift line each MAC cycle; mac_en = line output.
  - T=0 gives K=0: MAC is skipped and a zero result is written.
- DRAIN: RAM_LAT cycles, addresses held, no new issues, mac_en still driven by the line.
- WRITE (1 cycle):
  - fsm_wyj_wr=1, adres_probki_wyn_fir=n, mac_clr=1. The write captures the accumulator before it clears.
  - n=N-1 goes to DONE; otherwise n++, k=0, goes to MAC.
- Per-sample cost: K(n)+RAM_LAT+1 cycles.
- Total run: 1 + Σ(K(n)+RAM_LAT+1) + 1.
- DONE (1 cycle): done=1, muxes still 1, then IDLE with muxes 0 in the same cycle busy drops.
- fsm_wyj_wr and mac_en are never both 1 in the same cycle.
- Output addresses are 0 whenever not in MAC/DRAIN/WRITE.
- start during busy: ignored, latched N and T unchanged.
- a_rst mid-run: immediate return to IDLE, muxes released, shift line flushed, no done.

Optional Feature:
- FIR_CTRL_ABORT_EN:
  - Adds input abort (1) and output aborted (1).
  - abort=1 in any busy state: next cycle is IDLE, muxes 0, shift line flushed, aborted pulses 1 cycle, done not pulsed, no further fsm_wyj_wr.
  - abort in IDLE is ignored.
- Without the macro: neither port exists, and runs complete only by DONE or reset.

Decomposition:
- fir_pkg:
  - state enum fir_ctrl_state_t (IDLE, INIT, MAC, DRAIN, WRITE, DONE).
  - FIR_ADDR_WIDTH=13.
  - FIR_RAM_LAT=1.
- Sub-module fir_ctrl_lat_pipe: parameterised RAM_LAT-deep valid shift register with synchronous flush and async reset; produces mac_en.

Test Plan:
- N=4, T=3, RAM_LAT=1:
  - adres_probki_fir/adres_wsp sequences (0/0), (1/0, 0/1), (2/0, 1/1, 0/2), (3/0, 2/1, 1/2).
  - 4 writes to addresses 0..3.
  - done at cycle 1+(3+4+5+5)+1=19 after the start edge.
- N=0, T=5: INIT then DONE; done two cycles after start, no fsm_wyj_wr, no mac_en.
- N=3, T=0: three writes with mac_en never high; each sample takes RAM_LAT+1 cycles.
- start pulsed again mid-run with N=9: ignored, run ends after the original N, and mux selects are 1 exactly while busy.
- a_rst asserted during MAC of n=2: all outputs 0 asynchronously, no done; a new start runs cleanly from n=0.
- With FIR_CTRL_ABORT_EN, abort during DRAIN:
  - aborted pulse next cycle, muxes 0, no write for the current n.
  - RAM_LAT=3 run checks mac_en lags the address issue by 3 cycles.
